// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the round datapath.
package aes_pkg;

    localparam logic AES_ENC = 1'b0;
    localparam logic AES_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mc_state_e;

    function automatic logic [7:0] aes_mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] aes_mul4(input logic [7:0] a);
        return aes_mul2(aes_mul2(a));
    endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column.
module aes_mix_single_column
    import aes_pkg::*;
(
    input  logic        mode_i,
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] p0, p1, p2, p3;
    logic [7:0] u, v;

    assign a0 = col_i[7:0];
    assign a1 = col_i[15:8];
    assign a2 = col_i[23:16];
    assign a3 = col_i[31:24];

    // Inverse is a cheap pre-step followed by the forward matrix.
    assign u = aes_mul4(a0 ^ a2);
    assign v = aes_mul4(a1 ^ a3);

    always_comb begin
        p0 = a0;
        p1 = a1;
        p2 = a2;
        p3 = a3;
        if (mode_i == AES_DEC) begin
            p0 = a0 ^ u;
            p1 = a1 ^ v;
            p2 = a2 ^ u;
            p3 = a3 ^ v;
        end
    end

    assign col_o[7:0]   = aes_mul2(p0) ^ aes_mul2(p1) ^ p1 ^ p2 ^ p3;
    assign col_o[15:8]  = p0 ^ aes_mul2(p1) ^ aes_mul2(p2) ^ p2 ^ p3;
    assign col_o[23:16] = p0 ^ p1 ^ aes_mul2(p2) ^ aes_mul2(p3) ^ p3;
    assign col_o[31:24] = aes_mul2(p0) ^ p0 ^ p1 ^ p2 ^ aes_mul2(p3);

endmodule

// File: rtl/aes_mix_columns_iter.sv
// Column-serial MixColumns engine, one column per cycle.
// Define AES_MIX_COLUMNS_WIPE_EN to clear the result on output handshake.
module aes_mix_columns_iter
    import aes_pkg::*;
#(
    parameter int NumCols = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         mode_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] data_o
);

    localparam int CntW = $clog2(NumCols);

    mc_state_e                   state_q, state_d;
    logic [CntW-1:0]             col_cnt_q, col_cnt_d;
    logic [NumCols-1:0][31:0]    data_q, data_d;
    logic                        mode_q, mode_d;
    logic [31:0]                 col_sel, col_t;

    assign col_sel = data_q[col_cnt_q];
    assign data_o  = data_q;

    aes_mix_single_column u_col (
        .mode_i (mode_q),
        .col_i  (col_sel),
        .col_o  (col_t)
    );

    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        data_d      = data_q;
        mode_d      = mode_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    data_d    = data_i;
                    mode_d    = mode_i;
                    col_cnt_d = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                data_d[col_cnt_q] = col_t;
                col_cnt_d         = col_cnt_q + 1'b1;
                if (col_cnt_q == CntW'(NumCols - 1)) begin
                    col_cnt_d = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = IDLE;
`ifdef AES_MIX_COLUMNS_WIPE_EN
                    data_d  = '0;
`else
                    data_d  = data_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            col_cnt_q <= '0;
            data_q    <= '0;
            mode_q    <= AES_ENC;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
        end
    end

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Scoreboard bench for aes_mix_columns_iter using FIPS-197 column vectors.
module tb_aes_mix_columns_iter;

    logic         clk;
    logic         rst_n;
    logic         mode;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] din;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dout;

    int tests  = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    aes_mix_columns_iter dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mode_i      (mode),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .data_i      (din),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] col(input logic [7:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic [127:0] st(input logic [31:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: compare every output handshake against the scoreboard queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: got %h want none", dout);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    errors++;
                    $display("FAIL sb_data: got %h want %h", dout, e);
                end
            end
        end
    end

    // Called just after a posedge; returns just after the accept edge.
    task automatic send(input logic m, input logic [127:0] d,
                        input logic [127:0] e, input bit push);
        mode     = m;
        din      = d;
        in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        chk("accept_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din      = ~d;
        mode     = ~m;
    endtask

    // Cycles counted from the cycle in_valid was presented.
    task automatic wait_valid(input string name);
        int n;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 128'(n), 128'd5);
    endtask

    logic [127:0] enc_in, enc_out, dec2_in, dec2_out;
    logic [127:0] bp1_in, bp1_out, bp2_in, bp2_out, wipe_exp;
    bit stable, seen;

    initial begin
        enc_in  = st(col(8'hdb, 8'h13, 8'h53, 8'h45), col(8'hf2, 8'h0a, 8'h22, 8'h5c),
                     col(8'h01, 8'h01, 8'h01, 8'h01), col(8'hc6, 8'hc6, 8'hc6, 8'hc6));
        enc_out = st(col(8'h8e, 8'h4d, 8'ha1, 8'hbc), col(8'h9f, 8'hdc, 8'h58, 8'h9d),
                     col(8'h01, 8'h01, 8'h01, 8'h01), col(8'hc6, 8'hc6, 8'hc6, 8'hc6));
        dec2_in  = st(col(8'hd5, 8'hd5, 8'hd7, 8'hd6), col(8'h8e, 8'h4d, 8'ha1, 8'hbc),
                      col(8'h01, 8'h01, 8'h01, 8'h01), col(8'hc6, 8'hc6, 8'hc6, 8'hc6));
        dec2_out = st(col(8'hd4, 8'hd4, 8'hd4, 8'hd5), col(8'hdb, 8'h13, 8'h53, 8'h45),
                      col(8'h01, 8'h01, 8'h01, 8'h01), col(8'hc6, 8'hc6, 8'hc6, 8'hc6));
        bp1_in  = st(col(8'hd4, 8'hd4, 8'hd4, 8'hd5), col(8'h01, 8'h01, 8'h01, 8'h01),
                     col(8'hc6, 8'hc6, 8'hc6, 8'hc6), col(8'hf2, 8'h0a, 8'h22, 8'h5c));
        bp1_out = st(col(8'hd5, 8'hd5, 8'hd7, 8'hd6), col(8'h01, 8'h01, 8'h01, 8'h01),
                     col(8'hc6, 8'hc6, 8'hc6, 8'hc6), col(8'h9f, 8'hdc, 8'h58, 8'h9d));
        bp2_in  = st(col(8'h01, 8'h01, 8'h01, 8'h01), col(8'hc6, 8'hc6, 8'hc6, 8'hc6),
                     col(8'hdb, 8'h13, 8'h53, 8'h45), col(8'hf2, 8'h0a, 8'h22, 8'h5c));
        bp2_out = st(col(8'h01, 8'h01, 8'h01, 8'h01), col(8'hc6, 8'hc6, 8'hc6, 8'hc6),
                     col(8'h8e, 8'h4d, 8'ha1, 8'hbc), col(8'h9f, 8'hdc, 8'h58, 8'h9d));
`ifdef AES_MIX_COLUMNS_WIPE_EN
        wipe_exp = 128'd0;
`else
        wipe_exp = enc_out;
`endif

        rst_n     = 1'b0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_data", dout, 128'd0);

        // ENC FIPS vector, then check what the bus shows in IDLE.
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(1'b0, enc_in, enc_out, 1'b1);
        wait_valid("enc_latency");
        @(posedge clk);
        #1;
        chk("post_hs_valid", {127'd0, out_valid}, 128'd0);
        chk("post_hs_data", dout, wipe_exp);

        // DEC round trip and a second DEC vector.
        send(1'b1, enc_out, enc_in, 1'b1);
        wait_valid("dec_latency");
        @(posedge clk);
        #1;
        send(1'b1, dec2_in, dec2_out, 1'b1);
        wait_valid("dec2_latency");
        @(posedge clk);
        #1;

        // Backpressure: hold DONE for 10 cycles with a pending request.
        out_ready = 1'b0;
        send(1'b0, bp1_in, bp1_out, 1'b1);
        wait_valid("bp_latency");
        mode     = 1'b0;
        din      = bp2_in;
        in_valid = 1'b1;
        exp_q.push_back(bp2_out);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dout !== bp1_out || in_ready !== 1'b0 || out_valid !== 1'b1)
                stable = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("bp_hold", {127'd0, stable}, 128'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_ready", {127'd0, in_ready}, 128'd1);
        chk("bp_idle_valid", {127'd0, out_valid}, 128'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second_accepted", {127'd0, in_ready}, 128'd0);
        wait_valid("bp2_latency");
        @(posedge clk);
        #1;

        // Reset during the second BUSY cycle aborts the block.
        send(1'b0, enc_in, enc_out, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", {127'd0, in_ready}, 128'd1);
        chk("abort_data", dout, 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", {127'd0, seen}, 128'd0);

        chk("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
